// File: rtl/diferential_muxpga_loader.sv
// Host-side loader for the diferential_muxpga fabric: shifts config nibbles in (old config returned as readback), then runs the fabric for run_len cycles capturing io_out.
// Shift one cycle after accept, readback/result pulse one cycle after that; backpressure via cfg_ready, low outside IDLE/LOAD/LOADED or while start/clear is asserted.
module diferential_muxpga_loader #(
  parameter int ROWS       = 5,
  parameter int COLS       = 3,
  parameter int CLR_CYCLES = 2,
  parameter int RUN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             cfg_valid,
  input  logic [3:0]       cfg_nibble,
  output logic             cfg_ready,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  input  logic [3:0]       run_nibble,
  output logic             fab_reset,
  output logic [3:0]       fab_nibble,
  output logic [1:0]       fab_cmd,
  input  logic [7:0]       fab_q,
  output logic             rb_valid,
  output logic [3:0]       rb_nibble,
  output logic             res_valid,
  output logic [7:0]       res_data,
  output logic             res_last,
  output logic             loaded,
  output logic             busy
);
  localparam int NIBBLES = 2 * (ROWS - 1) * COLS;
  localparam int CNT_W   = $clog2(NIBBLES + 1);
  localparam int CLR_W   = $clog2(CLR_CYCLES + 1);
  localparam int RCNT_W  = RUN_W + 1;

  localparam logic [CNT_W-1:0]  NIB_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  NIB_LAST = CNT_W'(NIBBLES - 1);
  localparam logic [CLR_W-1:0]  CLR_ONE  = CLR_W'(1);
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RUN_ONE  = RCNT_W'(1);
  localparam logic [RCNT_W-1:0] RUN_MAX  = {1'b1, {RUN_W{1'b0}}};

  localparam logic [1:0] CMD_SHIFT = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_HOLD  = 2'd2;

  typedef enum logic [2:0] {S_CLR, S_IDLE, S_LOAD, S_LOADED, S_RUN} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    nib_cnt, nib_cnt_nx;
  logic [CLR_W-1:0]    clr_cnt, clr_cnt_nx;
  logic [RCNT_W-1:0]   run_cnt, run_cnt_nx;
  logic                loaded_nx;
  logic                accept;
  logic                run_end;

  always_comb begin
    state_nx   = state;
    nib_cnt_nx = nib_cnt;
    clr_cnt_nx = clr_cnt;
    run_cnt_nx = run_cnt;
    loaded_nx  = loaded;
    run_end    = 1'b0;
    cfg_ready  = ((state == S_IDLE) || (state == S_LOAD) || (state == S_LOADED)) && !start && !clear;
    accept     = cfg_ready && cfg_valid;

    if (clear) begin
      state_nx   = S_CLR;
      nib_cnt_nx = '0;
      clr_cnt_nx = '0;
      run_cnt_nx = '0;
      loaded_nx  = 1'b0;
    end else begin
      case (state)
        S_CLR: begin
          if (clr_cnt == CLR_LAST) begin
            state_nx   = S_IDLE;
            clr_cnt_nx = '0;
          end else begin
            clr_cnt_nx = clr_cnt + CLR_ONE;
          end
        end
        S_IDLE: begin
          if (accept) begin
            state_nx   = S_LOAD;
            nib_cnt_nx = NIB_ONE;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (nib_cnt == NIB_LAST) begin
              state_nx   = S_LOADED;
              nib_cnt_nx = '0;
              loaded_nx  = 1'b1;
            end else begin
              nib_cnt_nx = nib_cnt + NIB_ONE;
            end
          end
        end
        S_LOADED: begin
          if (start) begin
            state_nx   = S_RUN;
            run_cnt_nx = (run_len == '0) ? RUN_MAX : {1'b0, run_len};
          end else if (accept) begin
            state_nx   = S_LOAD;
            nib_cnt_nx = NIB_ONE;
            loaded_nx  = 1'b0;
          end
        end
        S_RUN: begin
          run_cnt_nx = run_cnt - RUN_ONE;
          if (run_cnt == RUN_ONE) begin
            state_nx = S_LOADED;
            run_end  = 1'b1;
          end
        end
        default: state_nx = S_CLR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_CLR;
      nib_cnt    <= '0;
      clr_cnt    <= '0;
      run_cnt    <= '0;
      loaded     <= 1'b0;
      fab_reset  <= 1'b1;
      fab_cmd    <= CMD_HOLD;
      fab_nibble <= 4'h0;
      rb_valid   <= 1'b0;
      rb_nibble  <= 4'h0;
      res_valid  <= 1'b0;
      res_data   <= 8'h00;
      res_last   <= 1'b0;
    end else begin
      state     <= state_nx;
      nib_cnt   <= nib_cnt_nx;
      clr_cnt   <= clr_cnt_nx;
      run_cnt   <= run_cnt_nx;
      loaded    <= loaded_nx;
      fab_reset <= (state_nx == S_CLR);

      // The fabric shifts on the edge that ends a CMD_SHIFT cycle; its old tail appears on fab_q[7:4].
      rb_valid <= (fab_cmd == CMD_SHIFT) && !clear;
      if ((fab_cmd == CMD_SHIFT) && !clear) begin
        rb_nibble <= fab_q[7:4];
      end

      res_valid <= (state == S_RUN) && !clear;
      res_last  <= run_end;
      if ((state == S_RUN) && !clear) begin
        res_data <= fab_q;
      end

      if (accept) begin
        fab_cmd    <= CMD_SHIFT;
        fab_nibble <= cfg_nibble;
      end else if (state_nx == S_RUN) begin
        fab_cmd    <= CMD_RUN;
        fab_nibble <= run_nibble;
      end else begin
        fab_cmd <= CMD_HOLD;
      end
    end
  end

  assign busy = (state == S_CLR) || (state == S_LOAD) || (state == S_RUN);

endmodule

// File: tb/tb_diferential_muxpga_loader.sv
// Scoreboarded bench for diferential_muxpga_loader: a fabric stand-in drives fab_q, a queue-based reference
// model predicts shifts, readback, run samples and per-cycle status; directed scenarios then random traffic.
module tb_diferential_muxpga_loader;
  localparam int NIB  = 24;
  localparam int CLRC = 2;
  localparam int P_CLR = 0, P_IDLE = 1, P_LOAD = 2, P_LOADED = 3, P_RUN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0, cfg_valid = 1'b0, start = 1'b0;
  logic [3:0] cfg_nibble = 4'h0, run_nibble = 4'h0;
  logic [7:0] run_len = 8'h00;
  logic       cfg_ready, fab_reset, rb_valid, res_valid, res_last, loaded, busy;
  logic [3:0] fab_nibble, rb_nibble;
  logic [1:0] fab_cmd;
  logic [7:0] fab_q, res_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  diferential_muxpga_loader dut (
    .clk(clk), .reset(rst_n), .clear(clear),
    .cfg_valid(cfg_valid), .cfg_nibble(cfg_nibble), .cfg_ready(cfg_ready),
    .start(start), .run_len(run_len), .run_nibble(run_nibble),
    .fab_reset(fab_reset), .fab_nibble(fab_nibble), .fab_cmd(fab_cmd), .fab_q(fab_q),
    .rb_valid(rb_valid), .rb_nibble(rb_nibble),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .loaded(loaded), .busy(busy)
  );

  // Fabric stand-in: a 24-deep nibble chain whose tail shows on fab_q[7:4]; the low nibble mixes the
  // current input with a count of run cycles so every run sample is distinct.
  logic [3:0] chain [NIB];
  logic [7:0] rcount = 8'h00;
  assign fab_q = {chain[NIB-1], fab_nibble ^ rcount[3:0]};

  always @(posedge clk) begin
    if (fab_reset) begin
      for (int i = 0; i < NIB; i++) chain[i] <= 4'h0;
    end else if (rst_n && fab_cmd == 2'd0) begin
      chain[0] <= fab_nibble;
      for (int i = 1; i < NIB; i++) chain[i] <= chain[i-1];
    end
    if (rst_n && fab_cmd == 2'd1) rcount <= rcount + 8'd1;
  end

  // Reference model
  int         m_phase = P_CLR, m_clr_left = CLRC, m_count = 0, m_run_left = 0, m_runs = 0, m_exp_cmd = 2;
  bit         m_loaded = 1'b0, m_pend = 1'b0, m_acc = 1'b0, m_rdy = 1'b0;
  logic [3:0] m_pend_rb = 4'h0, m_prev_rn = 4'h0;
  logic [3:0] resident [$];
  logic [3:0] q_shift [$];
  logic [3:0] q_rb [$];
  logic [8:0] q_res [$];
  logic [3:0] vals [$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  task automatic zero_resident();
    resident.delete();
    repeat (NIB) resident.push_back(4'h0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_CLR; m_clr_left = CLRC; m_count = 0; m_loaded = 1'b0;
      m_pend = 1'b0; m_exp_cmd = 2; m_prev_rn = run_nibble;
      zero_resident();
      q_shift.delete(); q_rb.delete(); q_res.delete();
    end else begin
      m_acc = (m_phase inside {P_IDLE, P_LOAD, P_LOADED}) && !start && !clear && cfg_valid;
      if (m_pend && !clear) q_rb.push_back(m_pend_rb);
      if (m_phase == P_RUN) begin
        if (!clear) q_res.push_back({m_run_left == 1, resident[0], m_prev_rn ^ 4'(m_runs)});
        m_runs++;
      end
      m_pend = m_acc;
      if (m_acc) begin
        q_shift.push_back(cfg_nibble);
        m_pend_rb = resident.pop_front();
        resident.push_back(cfg_nibble);
      end
      if (clear) begin
        m_phase = P_CLR; m_clr_left = CLRC; m_count = 0; m_loaded = 1'b0;
        zero_resident();
      end else begin
        case (m_phase)
          P_CLR: begin
            m_clr_left--;
            if (m_clr_left == 0) m_phase = P_IDLE;
          end
          P_IDLE: if (m_acc) begin m_phase = P_LOAD; m_count = 1; end
          P_LOAD: if (m_acc) begin
            m_count++;
            if (m_count == NIB) begin m_phase = P_LOADED; m_loaded = 1'b1; m_count = 0; end
          end
          P_LOADED: begin
            if (start) begin
              m_phase = P_RUN;
              m_run_left = (run_len == 8'd0) ? 256 : int'(run_len);
            end else if (m_acc) begin
              m_phase = P_LOAD; m_count = 1; m_loaded = 1'b0;
            end
          end
          default: begin
            m_run_left--;
            if (m_run_left == 0) m_phase = P_LOADED;
          end
        endcase
      end
      m_exp_cmd = clear ? 2 : m_acc ? 0 : (m_phase == P_RUN) ? 1 : 2;
      m_prev_rn = run_nibble;
    end
  end

  // Monitor
  logic [5:0] exp_st;
  always @(negedge clk) begin
    m_rdy  = (m_phase inside {P_IDLE, P_LOAD, P_LOADED}) && !start && !clear;
    exp_st = {m_rdy, m_phase == P_CLR, 2'(m_exp_cmd), m_loaded, m_phase inside {P_CLR, P_LOAD, P_RUN}};
    check("status{rdy,frst,cmd,ld,busy}", int'({cfg_ready, fab_reset, fab_cmd, loaded, busy}), int'(exp_st));
    if (fab_cmd == 2'd0) begin
      if (q_shift.size() == 0) unexpected("shift_nibble", int'(fab_nibble));
      else check("shift_nibble", int'(fab_nibble), int'(q_shift.pop_front()));
    end
    if (rb_valid) begin
      if (q_rb.size() == 0) unexpected("rb_nibble", int'(rb_nibble));
      else check("rb_nibble", int'(rb_nibble), int'(q_rb.pop_front()));
    end
    if (res_valid) begin
      if (q_res.size() == 0) unexpected("res{last,data}", int'({res_last, res_data}));
      else check("res{last,data}", int'({res_last, res_data}), int'(q_res.pop_front()));
    end
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0; start = 1'b0; clear = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load(input logic [3:0] v[$], input bit gap3);
    int i = 0;
    int cyc = 0;
    while (i < v.size() && cyc < 200) begin
      cfg_valid  = !(gap3 && (cyc % 3 == 2));
      cfg_nibble = v[i];
      tick();
      cyc++;
      if (m_pend) i++;
    end
    cfg_valid = 1'b0;
    check("load_accepted_count", i, v.size());
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin tick(); n++; end
    check("wait_phase", m_phase, ph);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (4) tick();
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < NIB; i++) vals.push_back(4'(i));
    load(vals, 1'b1);
    idle(3);

    vals.delete();
    repeat (NIB) vals.push_back(4'hA);
    load(vals, 1'b0);
    idle(3);

    wait_phase(P_LOADED, 50);
    run_nibble = 4'h5; run_len = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_phase(P_LOADED, 20);
    idle(3);

    run_len = 8'd2; start = 1'b1; cfg_valid = 1'b1; cfg_nibble = 4'h3;
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    wait_phase(P_LOADED, 20);
    idle(3);

    vals.delete();
    repeat (10) vals.push_back(4'($urandom));
    load(vals, 1'b0);
    idle(3);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(4);
    vals.delete();
    repeat (NIB) vals.push_back(4'($urandom));
    load(vals, 1'b0);
    idle(3);

    run_len = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle(6);

    for (int c = 0; c < 4000; c++) begin
      clear      = ($urandom_range(0, 149) == 0);
      start      = (m_phase == P_LOADED) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      cfg_valid  = ($urandom_range(0, 3) != 0);
      cfg_nibble = 4'($urandom);
      run_len    = ($urandom_range(0, 39) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      run_nibble = 4'($urandom);
      tick();
    end
    idle(1);
    if (m_phase == P_RUN) wait_phase(P_LOADED, 300);
    idle(4);

    check("q_shift_drained", q_shift.size(), 0);
    check("q_rb_drained", q_rb.size(), 0);
    check("q_res_drained", q_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
